// File: rtl/ps2_rx_if.sv
// PS/2 receiver bundle: raw keyboard lines in, decoded scan-code events out.
// master = the receiver, slave = the line driver / event consumer.
interface ps2_rx_if;
    logic       clkps2;
    logic       dataps2;
    logic [7:0] scancode;
    logic       extended;
    logic       released;
    logic       scancode_valid;
    logic       frame_err;

    modport master (
        input  clkps2,
        input  dataps2,
        output scancode,
        output extended,
        output released,
        output scancode_valid,
        output frame_err
    );

    modport slave (
        output clkps2,
        output dataps2,
        input  scancode,
        input  extended,
        input  released,
        input  scancode_valid,
        input  frame_err
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch the lines, deserialise
// 11-bit frames and fold E0/F0 prefixes into flags on the following code byte.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 28000
) (
    input  logic      clk,
    input  logic      rst_n,
    ps2_rx_if.master  bus
);

    localparam int FL_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [FL_W-1:0] FL_LIMIT = FL_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [1:0]            r_c_sync;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_d_dly;
    logic [FL_W-1:0]       r_flt_cnt;
    logic                  r_ps2c_f;
    logic                  r_fall;
    logic [TO_W-1:0]       r_to_cnt;
    logic [1:0]            r_state;
    logic [7:0]            r_shift;
    logic [2:0]            r_bitcnt;
    logic                  r_parity;
    logic                  r_ext_pend;
    logic                  r_rel_pend;
    logic [7:0]            r_scancode;
    logic                  r_extended;
    logic                  r_released;
    logic                  r_valid;
    logic                  r_valid_d;
    logic                  r_err;

    logic                  w_c_s;
    logic                  w_data;
    logic [1:0]            w_next_state;
    logic                  w_frame_done;
    logic                  w_good;
    logic                  w_timeout;

    assign w_c_s  = r_c_sync[1];
    assign w_data = r_d_dly[FILTER_LEN-1];

    // Two-flop synchronisers, plus a data delay matching the clock filter depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
            r_d_dly  <= {FILTER_LEN{1'b1}};
        end else begin
            r_c_sync <= {r_c_sync[0], bus.clkps2};
            r_d_sync <= {r_d_sync[0], bus.dataps2};
            r_d_dly  <= {r_d_dly[FILTER_LEN-2:0], r_d_sync[1]};
        end
    end

    // Clock deglitch: level flips only after FILTER_LEN differing samples in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flt_cnt <= {FL_W{1'b0}};
            r_ps2c_f  <= 1'b1;
            r_fall    <= 1'b0;
        end else if (w_c_s == r_ps2c_f) begin
            r_flt_cnt <= {FL_W{1'b0}};
            r_fall    <= 1'b0;
        end else if (r_flt_cnt == FL_LIMIT) begin
            r_flt_cnt <= {FL_W{1'b0}};
            r_ps2c_f  <= w_c_s;
            r_fall    <= r_ps2c_f;
        end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
            r_fall    <= 1'b0;
        end
    end

    // Next-state decode; a fall always wins over a coincident timeout
    always_comb begin
        w_next_state = r_state;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        w_good       = w_data && (^{r_shift, r_parity});
        if (r_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_data) begin
                        w_next_state = ST_DATA;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (r_bitcnt == 3'd7) begin
                        w_next_state = ST_PARITY;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
                ST_PARITY: w_next_state = ST_STOP;
                ST_STOP: begin
                    w_next_state = ST_IDLE;
                    w_frame_done = 1'b1;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end else if ((r_state != ST_IDLE) && (r_to_cnt == TO_LIMIT)) begin
            w_next_state = ST_IDLE;
            w_timeout    = 1'b1;
        end else begin
            w_next_state = r_state;
        end
    end

    // State register and saturating inactivity counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (r_fall || (r_state == ST_IDLE)) begin
                r_to_cnt <= {TO_W{1'b0}};
            end else if (r_to_cnt != TO_LIMIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt;
            end
        end
    end

    // Frame deserialiser: data bits enter at bit 7, LSB arrives first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_parity <= 1'b0;
        end else if (r_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_data) begin
                        r_shift  <= 8'h00;
                        r_bitcnt <= 3'd0;
                    end else begin
                        r_shift  <= r_shift;
                        r_bitcnt <= r_bitcnt;
                    end
                end
                ST_DATA: begin
                    r_shift  <= {w_data, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
                ST_PARITY: r_parity <= w_data;
                default: begin
                    r_shift  <= r_shift;
                    r_bitcnt <= r_bitcnt;
                end
            endcase
        end else begin
            r_shift  <= r_shift;
            r_bitcnt <= r_bitcnt;
        end
    end

    // Event outputs, prefix bookkeeping and error strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scancode <= 8'h00;
            r_extended <= 1'b0;
            r_released <= 1'b0;
            r_valid    <= 1'b0;
            r_valid_d  <= 1'b0;
            r_err      <= 1'b0;
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_valid_d <= r_valid;
            if (r_valid_d && !r_valid) begin
                r_extended <= 1'b0;
                r_released <= 1'b0;
            end else begin
                r_extended <= r_extended;
                r_released <= r_released;
            end
            if (w_frame_done) begin
                if (!w_good) begin
                    r_err      <= 1'b1;
                    r_ext_pend <= 1'b0;
                    r_rel_pend <= 1'b0;
                end else if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_rel_pend <= 1'b1;
                end else begin
                    r_scancode <= r_shift;
                    r_extended <= r_ext_pend;
                    r_released <= r_rel_pend;
                    r_valid    <= 1'b1;
                    r_ext_pend <= 1'b0;
                    r_rel_pend <= 1'b0;
                end
            end else if (w_timeout) begin
                r_err      <= 1'b1;
                r_ext_pend <= 1'b0;
                r_rel_pend <= 1'b0;
            end else begin
                r_ext_pend <= r_ext_pend;
                r_rel_pend <= r_rel_pend;
            end
        end
    end

    assign bus.scancode       = r_scancode;
    assign bus.extended       = r_extended;
    assign bus.released       = r_released;
    assign bus.scancode_valid = r_valid;
    assign bus.frame_err      = r_err;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed plan cases followed by random frames,
// judged against a byte-level model of the prefix/event rules.
module tb_ps2_rx;

    localparam int FL = 8;
    localparam int TO = 2000;
    localparam int H  = 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ps2_rx_if bus ();

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge away from DUT updates
    int         obs_valid = 0;
    int         obs_err   = 0;
    logic [7:0] cap_code  = 8'h00;
    logic       cap_ext   = 1'b0;
    logic       cap_rel   = 1'b0;

    always @(negedge clk) begin
        if (bus.scancode_valid) begin
            obs_valid <= obs_valid + 1;
            cap_code  <= bus.scancode;
            cap_ext   <= bus.extended;
            cap_rel   <= bus.released;
        end
        if (bus.frame_err) obs_err <= obs_err + 1;
        if (bus.scancode_valid && bus.frame_err) check_eq("valid_err_exclusive", 32'd1, 32'd0);
    end

    // Reference model state: pending prefixes and last delivered code
    logic       m_ext  = 1'b0;
    logic       m_rel  = 1'b0;
    logic [7:0] m_code = 8'h00;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.dataps2 = fr[i];
            if (i == glitch_bit) begin
                wait_cyc(H / 3);
                bus.clkps2 = 1'b0;
                wait_cyc(FL - 2);
                bus.clkps2 = 1'b1;
                wait_cyc(H - H / 3 - (FL - 2));
            end else begin
                wait_cyc(H);
            end
            bus.clkps2 = 1'b0;
            wait_cyc(H);
            bus.clkps2 = 1'b1;
        end
        bus.dataps2 = 1'b1;
    endtask

    task automatic send_and_check(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                  input int glitch_bit);
        int v0;
        int e0;
        bit exp_v;
        bit exp_e;
        v0 = obs_valid;
        e0 = obs_err;
        send_frame(b, bad_par, bad_stop, 11, glitch_bit);
        wait_cyc(20);
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (bad_par || bad_stop) begin
            exp_e = 1'b1;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            exp_v = 1'b1;
        end
        check_eq("valid_count", 32'(obs_valid - v0), 32'(exp_v));
        check_eq("err_count", 32'(obs_err - e0), 32'(exp_e));
        if (exp_v) begin
            check_eq("event_code", 32'(cap_code), 32'(b));
            check_eq("event_extended", 32'(cap_ext), 32'(m_ext));
            check_eq("event_released", 32'(cap_rel), 32'(m_rel));
            m_code = b;
            m_ext  = 1'b0;
            m_rel  = 1'b0;
        end
        check_eq("scancode_hold", 32'(bus.scancode), 32'(m_code));
        check_eq("extended_idle", 32'(bus.extended), 32'd0);
        check_eq("released_idle", 32'(bus.released), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_scancode"}, 32'(bus.scancode), 32'd0);
        check_eq({tag, "_extended"}, 32'(bus.extended), 32'd0);
        check_eq({tag, "_released"}, 32'(bus.released), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.scancode_valid), 32'd0);
        check_eq({tag, "_err"}, 32'(bus.frame_err), 32'd0);
    endtask

    initial begin
        int v0;
        int e0;
        logic [7:0] rb;
        bit bp;
        bit bs;
        int gb;

        bus.clkps2  = 1'b1;
        bus.dataps2 = 1'b1;
        rst_n       = 1'b0;
        wait_cyc(5);
        @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_cyc(5);

        // Plain key, break, extended+break, and prefix-free follow-up
        send_and_check(8'h1C, 1'b0, 1'b0, -1);
        send_and_check(8'hF0, 1'b0, 1'b0, -1);
        send_and_check(8'h1C, 1'b0, 1'b0, -1);
        send_and_check(8'hE0, 1'b0, 1'b0, -1);
        send_and_check(8'hF0, 1'b0, 1'b0, -1);
        send_and_check(8'h75, 1'b0, 1'b0, -1);
        send_and_check(8'h1C, 1'b0, 1'b0, -1);

        // Bad parity, then a prefix dropped by a bad stop bit
        send_and_check(8'h1C, 1'b1, 1'b0, -1);
        send_and_check(8'hF0, 1'b0, 1'b0, -1);
        send_and_check(8'h1C, 1'b0, 1'b1, -1);
        send_and_check(8'h2A, 1'b0, 1'b0, -1);

        // Timeout: start bit plus four data bits, then silence
        v0 = obs_valid;
        e0 = obs_err;
        send_frame(8'h1C, 1'b0, 1'b0, 5, -1);
        wait_cyc(TO + 10);
        check_eq("timeout_err", 32'(obs_err - e0), 32'd1);
        check_eq("timeout_valid", 32'(obs_valid - v0), 32'd0);
        m_ext = 1'b0;
        m_rel = 1'b0;
        send_and_check(8'h1C, 1'b0, 1'b0, -1);

        // Short clock glitch between bits must not consume a bit
        send_and_check(8'h1C, 1'b0, 1'b0, 4);

        // Reset mid-frame with a break prefix pending
        send_and_check(8'h5A, 1'b0, 1'b0, -1);
        send_and_check(8'hF0, 1'b0, 1'b0, -1);
        v0 = obs_valid;
        e0 = obs_err;
        send_frame(8'h33, 1'b0, 1'b0, 6, -1);
        rst_n = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        wait_cyc(20);
        check_eq("midreset_no_strobe", 32'(obs_valid - v0), 32'd0);
        check_eq("midreset_no_err", 32'(obs_err - e0), 32'd0);
        m_code = 8'h00;
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        send_and_check(8'h1C, 1'b0, 1'b0, -1);

        // Randomised frames with prefixes, errors and glitches
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 9))
                0:       rb = 8'hE0;
                1:       rb = 8'hF0;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 19) == 0);
            gb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
            send_and_check(rb, bp, bs, gb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard receiver that sits directly upstream of `sistema` and turns the raw `clkps2`/`dataps2` lines into complete scan-code events. It synchronises and deglitches the PS/2 lines and deserialises 11-bit frames: start bit, 8 data bits LSB first, odd parity, stop bit. It also folds the `E0` (extended) and `F0` (break) prefix bytes into flags on the following code byte. It runs on the same system `clk` that feeds `sistema`.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes level (2..16).
- `TIMEOUT`, 28000: `clk` cycles without a filtered falling edge that abort a frame in progress (about 1 ms at 28 MHz).

Ports:
- `clk`, in, 1: system clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `clkps2`, in, 1: raw PS/2 clock, asynchronous to `clk`.
- `dataps2`, in, 1: raw PS/2 data, asynchronous to `clk`.
- `scancode`, out, 8: last complete non-prefix code byte; holds its value between events.
- `extended`, out, 1: `E0` preceded `scancode`; valid while `scancode_valid` is high.
- `released`, out, 1: `F0` preceded `scancode`; valid while `scancode_valid` is high.
- `scancode_valid`, out, 1: one-cycle strobe marking a new event.
- `frame_err`, out, 1: one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- **Synchronisers:** both lines pass through 2-FF synchronisers. The synchronised data is delayed by the same filter depth, so data stays aligned with the filtered clock.
- **Filter:** `ps2c_f` (reset value 1) takes the synchronised clock level only after `FILTER_LEN` equal consecutive samples. `fall` is a one-cycle pulse when `ps2c_f` goes 1→0. Data is sampled only on `fall`.
- **State machine** (states IDLE, DATA, PARITY, STOP; reset state IDLE):
  - IDLE: on `fall` with data=0, clear the shift register and set bitcnt=0, then go to DATA. On `fall` with data=1, stay in IDLE with no error.
  - DATA: on `fall`, shift the data bit into bit 7 (shift right) and increment bitcnt. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, evaluate the frame and go to IDLE. The frame is good when stop=1 and the XOR of the 8 data bits and the parity bit is 1.
- **Good frame, byte `E0`:** set `ext_pend`; no strobe.
- **Good frame, byte `F0`:** set `rel_pend`; no strobe.
- **Good frame, any other byte:** `scancode`←byte, `extended`←`ext_pend`, `released`←`rel_pend`, pulse `scancode_valid`, clear both pending flags.
- **Bad frame:** pulse `frame_err`, clear both pending flags, leave `scancode` unchanged.
- **Timeout:** a counter clears on every `fall` and in IDLE, and counts otherwise. Reaching `TIMEOUT`−1 in a non-IDLE state forces IDLE, pulses `frame_err` and clears both pending flags. The counter saturates and does not wrap.
- `extended` and `released` are cleared to 0 the cycle after `scancode_valid` drops.

## Timing
- **Reset values:** `scancode`=00, `extended`=0, `released`=0, `scancode_valid`=0, `frame_err`=0, `ps2c_f`=1, state IDLE, pending flags 0, counters 0.
- **Reset mid-frame:** abandons the frame immediately with no strobe.
- **Latency:** a pin-level falling edge produces `fall` 2+`FILTER_LEN` cycles later. `scancode_valid`/`frame_err` go high in the cycle after the stop-bit `fall` and stay high for exactly 1 cycle.
- `scancode`, `extended` and `released` change in the same cycle that `scancode_valid` rises.
- **Simultaneous events:** a timeout and a `fall` in the same cycle are resolved in favour of the `fall`, and no error is raised. `scancode_valid` and `frame_err` are never high together.
- Pulses on `clkps2` shorter than `FILTER_LEN` cycles produce no `fall`.
- There is no back-pressure. The consumer must accept `scancode_valid` as a single-cycle event, and a new event cannot occur within 11 PS/2 clock periods.

## Test plan
- **Plain key:** frame byte `1C` with parity 0 → single `scancode_valid`, `scancode`=`1C`, `extended`=0, `released`=0, `frame_err` never high.
- **Break and extended prefixes:**
  - `F0`,`1C` → exactly one strobe, `scancode`=`1C`, `released`=1, `extended`=0.
  - `E0`,`F0`,`75` → one strobe, `scancode`=`75`, `extended`=1, `released`=1.
  - A following `1C` → `extended`=0, `released`=0.
- **Bad parity:** `1C` sent with parity 1 → `frame_err` high for 1 cycle, no `scancode_valid`, `scancode` keeps its prior value.
- **Prefix dropped by error:** `F0`, then `1C` with a bad stop bit (0), then a good `2A` → one `frame_err`, then a strobe with `scancode`=`2A` and `released`=0 (pending cleared by the error).
- **Timeout:** start bit plus 4 data bits, then idle for `TIMEOUT`+10 cycles → one `frame_err`, back to IDLE. The next good `1C` frame decodes correctly.
- **Glitch and reset:**
  - `clkps2` low pulse of `FILTER_LEN`−2 cycles between bits → no bit consumed; the following frame decodes `1C`.
  - `rst_n` low mid-frame → all outputs 00/0 and no strobe.
